apb_master_arbiter: RTL and testbench

// - Shares one apb_master_if among NUM_REQ requesters; sits between the requesters and the master's other_* port.
// - Round-robin grant; latches the winner's command and holds it stable on mst_* for the whole transfer.
// - Returns rdata/error to the winner with a one-cycle ready pulse, then drops mst_sel so the master returns to its reset state.

---
 rtl/apb_master_arbiter_pkg.sv | 10 +
 rtl/apb_master_arbiter_if.sv | 25 ++
 rtl/apb_master_arbiter_rr_picker.sv | 24 ++
 rtl/apb_master_arbiter.sv | 103 ++++++++++
 tb/tb_apb_master_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/apb_master_arbiter_pkg.sv
// Shared types for the APB master arbiter: FSM state encoding.
package apb_master_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

endpackage : apb_master_arbiter_pkg

// File: rtl/apb_master_arbiter_if.sv
// Command/response bundle between the arbiter and the shared APB master's other_* port.
interface apb_master_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mst_sel_out;
    logic              mst_write_out;
    logic [ADDR_W-1:0] mst_addr_out;
    logic [DATA_W-1:0] mst_wdata_out;
    logic              mst_error_out;
    logic              mst_ready_in;
    logic              mst_error_in;
    logic [DATA_W-1:0] mst_rdata_in;

    // The arbiter issues commands; the APB master answers them.
    modport master (
        output mst_sel_out, mst_write_out, mst_addr_out, mst_wdata_out, mst_error_out,
        input  mst_ready_in, mst_error_in, mst_rdata_in
    );

    modport slave (
        input  mst_sel_out, mst_write_out, mst_addr_out, mst_wdata_out, mst_error_out,
        output mst_ready_in, mst_error_in, mst_rdata_in
    );
endinterface : apb_master_arbiter_if

// File: rtl/apb_master_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after the pointer, modulo NUM_REQ.
module apb_rr_picker #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_valid
);
    int w_cand;

    // Scan from the farthest offset down so the nearest requester overwrites last.
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        o_idx   = '0;
        o_valid = |i_req;
        w_cand  = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = (int'(i_ptr) + k) % NUM_REQ;
            if (i_req[w_cand]) o_idx = ID_W'(w_cand);
        end
    end
endmodule : apb_rr_picker

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master among NUM_REQ requesters; the command is frozen for the whole transfer.
module apb_master_arbiter
    import apb_master_arbiter_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int APB_ADDR_WIDTH = 32,
    parameter  int APB_DATA_WIDTH = 32,
    localparam int ID_W           = $clog2(NUM_REQ)
) (
    input  logic                                apb_clk_in,
    input  logic                                apb_rstn_in,
    input  logic [NUM_REQ-1:0]                  req_sel_in,
    input  logic [NUM_REQ-1:0]                  req_write_in,
    input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]   req_addr_in,
    input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]   req_wdata_in,
    output logic [NUM_REQ-1:0]                  req_ready_out,
    output logic                                req_error_out,
    output logic [APB_DATA_WIDTH-1:0]           req_rdata_out,
    apb_master_arbiter_if.master                mst,
    output logic [ID_W-1:0]                     grant_id_out
);
    arb_state_e                r_state;
    logic [ID_W-1:0]           r_ptr;
    logic [ID_W-1:0]           r_grant;
    logic                      r_sel;
    logic                      r_write;
    logic [APB_ADDR_WIDTH-1:0] r_addr;
    logic [APB_DATA_WIDTH-1:0] r_wdata;
    logic [NUM_REQ-1:0]        r_ready;
    logic                      r_error;
    logic [APB_DATA_WIDTH-1:0] r_rdata;

    logic [ID_W-1:0]           w_win;
    logic                      w_win_valid;

    apb_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .i_req   (req_sel_in),
        .i_ptr   (r_ptr),
        .o_idx   (w_win),
        .o_valid (w_win_valid)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            r_state <= ARB_IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_sel   <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ready <= '0;
            r_error <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    r_ready <= '0;
                    // The master keeps ready high until it is back in reset; wait for it to fall.
                    if (w_win_valid && !mst.mst_ready_in) begin
                        r_grant <= w_win;
                        r_sel   <= 1'b1;
                        r_write <= req_write_in[w_win];
                        r_addr  <= req_addr_in[w_win*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                        r_wdata <= req_wdata_in[w_win*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                        r_state <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (mst.mst_ready_in) begin
                        r_rdata <= mst.mst_rdata_in;
                        r_error <= mst.mst_error_in;
                        r_ready <= NUM_REQ'(1) << r_grant;
                        r_sel   <= 1'b0;
                        r_state <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    r_ready <= '0;
                    r_ptr   <= (r_grant == ID_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
                    r_state <= ARB_IDLE;
                end
                default: begin
                    r_ready <= '0;
                    r_sel   <= 1'b0;
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign mst.mst_sel_out   = r_sel;
    assign mst.mst_write_out = r_write;
    assign mst.mst_addr_out  = r_addr;
    assign mst.mst_wdata_out = r_wdata;
    assign mst.mst_error_out = 1'b0;

    assign req_ready_out = r_ready;
    assign req_error_out = r_error;
    assign req_rdata_out = r_rdata;
    assign grant_id_out  = r_grant;
endmodule : apb_master_arbiter

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter; the bench plays the shared APB master.
module tb_apb_master_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk;
    logic            rstn;
    logic [N-1:0]    req_sel;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic            req_error;
    logic [DW-1:0]   req_rdata;
    logic [1:0]      grant_id;

    int total = 0;
    int bad   = 0;
    int pulse_cnt [N];
    int pulse_base [N];

    apb_master_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mst_if ();

    apb_master_arbiter #(.NUM_REQ(N), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW)) dut (
        .apb_clk_in    (clk),
        .apb_rstn_in   (rstn),
        .req_sel_in    (req_sel),
        .req_write_in  (req_write),
        .req_addr_in   (req_addr),
        .req_wdata_in  (req_wdata),
        .req_ready_out (req_ready),
        .req_error_out (req_error),
        .req_rdata_out (req_rdata),
        .mst           (mst_if.master),
        .grant_id_out  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tally ready pulses per requester, sampled away from the active edge.
    initial for (int i = 0; i < N; i++) pulse_cnt[i] = 0;
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) if (req_ready[i]) pulse_cnt[i]++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        req_write[i]        = wr;
        req_addr[i*AW +: AW]  = addr;
        req_wdata[i*DW +: DW] = wd;
    endtask

    // Waits (bounded) for mst_sel and checks the frozen command.
    task automatic wait_grant(input int id, input logic [31:0] addr, input logic wr, input logic [31:0] wd);
        for (int i = 0; i < 8 && mst_if.mst_sel_out !== 1'b1; i++) @(negedge clk);
        check("grant_sel", 32'(mst_if.mst_sel_out), 32'd1);
        check("grant_id", 32'(grant_id), 32'(id));
        check("grant_addr", mst_if.mst_addr_out, addr);
        check("grant_write", 32'(mst_if.mst_write_out), 32'(wr));
        check("grant_wdata", mst_if.mst_wdata_out, wd);
    endtask

    // Finishes the transfer as the master would, optionally keeping ready high afterwards.
    task automatic complete(input int id, input logic [31:0] rd, input logic err,
                            input int waits, input int hold);
        for (int w = 0; w < waits; w++) begin
            @(negedge clk);
            check("wait_sel", 32'(mst_if.mst_sel_out), 32'd1);
            check("wait_ready", 32'(req_ready), 32'd0);
        end
        mst_if.mst_ready_in = 1'b1;
        mst_if.mst_rdata_in = rd;
        mst_if.mst_error_in = err;
        @(negedge clk);
        check("pulse", 32'(req_ready), 32'd1 << id);
        check("rdata", req_rdata, rd);
        check("error", 32'(req_error), 32'(err));
        check("sel_drop", 32'(mst_if.mst_sel_out), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_sel", 32'(mst_if.mst_sel_out), 32'd0);
            check("hold_ready", 32'(req_ready), 32'd0);
        end
        mst_if.mst_ready_in = 1'b0;
        mst_if.mst_rdata_in = '0;
        mst_if.mst_error_in = 1'b0;
        @(negedge clk);
        check("pulse_end", 32'(req_ready), 32'd0);
    endtask

    initial begin
        rstn      = 1'b0;
        req_sel   = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        mst_if.mst_ready_in = 1'b0;
        mst_if.mst_error_in = 1'b0;
        mst_if.mst_rdata_in = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_sel", 32'(mst_if.mst_sel_out), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_rdata", req_rdata, 32'd0);
        check("rst_addr", mst_if.mst_addr_out, 32'd0);
        check("rst_mst_err", 32'(mst_if.mst_error_out), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Single read from req0 with two wait states
        set_req(0, 1'b0, 32'h100, 32'h0);
        req_sel = 4'b0001;
        @(negedge clk);
        check("lat1_sel", 32'(mst_if.mst_sel_out), 32'd1);
        wait_grant(0, 32'h100, 1'b0, 32'h0);
        complete(0, 32'hDEADBEEF, 1'b0, 2, 0);
        req_sel = '0;

        // Fresh pointer, then all four requesting continuously: 0,1,2,3,0
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, i[0], 32'h1000 + 32'(i) * 32'h10, 32'hA0 + 32'(i));
        for (int i = 0; i < N; i++) pulse_base[i] = pulse_cnt[i];
        req_sel = 4'b1111;
        for (int t = 0; t < N; t++) begin
            wait_grant(t, 32'h1000 + 32'(t) * 32'h10, t[0], 32'hA0 + 32'(t));
            complete(t, t[0] ? 32'h0 : 32'h5500 + 32'(t), 1'b0, 1, 0);
        end
        for (int i = 0; i < N; i++) check("rr_one_pulse", 32'(pulse_cnt[i] - pulse_base[i]), 32'd1);
        wait_grant(0, 32'h1000, 1'b0, 32'hA0);
        complete(0, 32'h1234, 1'b0, 0, 0);
        req_sel = '0;

        // req2 changes addr and drops sel mid-transfer; command stays frozen, transfer completes
        set_req(2, 1'b0, 32'h40, 32'h0);
        req_sel = 4'b0100;
        wait_grant(2, 32'h40, 1'b0, 32'h0);
        set_req(2, 1'b1, 32'h80, 32'hFFFF);
        req_sel = 4'b0001;
        @(negedge clk);
        check("frozen_addr", mst_if.mst_addr_out, 32'h40);
        check("frozen_write", 32'(mst_if.mst_write_out), 32'd0);
        check("frozen_grant", 32'(grant_id), 32'd2);
        req_sel = '0;
        complete(2, 32'h0BAD_F00D, 1'b0, 1, 0);

        // Master timeout: error returned with the pulse, next request proceeds normally
        set_req(0, 1'b1, 32'h200, 32'hCAFE);
        req_sel = 4'b0001;
        wait_grant(0, 32'h200, 1'b1, 32'hCAFE);
        req_sel = '0;
        complete(0, 32'h0, 1'b1, 6, 0);
        set_req(1, 1'b0, 32'h300, 32'h0);
        req_sel = 4'b0010;
        wait_grant(1, 32'h300, 1'b0, 32'h0);
        req_sel = '0;
        complete(1, 32'h77, 1'b0, 0, 0);

        // Reset while BUSY: sel drops at once, no pulse, pointer back to 0
        set_req(0, 1'b0, 32'h400, 32'h0);
        req_sel = 4'b0001;
        wait_grant(0, 32'h400, 1'b0, 32'h0);
        rstn = 1'b0;
        #1;
        check("rstbusy_sel", 32'(mst_if.mst_sel_out), 32'd0);
        check("rstbusy_ready", 32'(req_ready), 32'd0);
        req_sel = '0;
        @(negedge clk);
        check("rstbusy_ready2", 32'(req_ready), 32'd0);
        rstn = 1'b1;
        set_req(3, 1'b1, 32'h500, 32'h33);
        req_sel = 4'b1000;
        wait_grant(3, 32'h500, 1'b1, 32'h33);
        req_sel = '0;
        complete(3, 32'h0, 1'b0, 0, 0);

        // Ready held 3 extra cycles: no grant until it falls; pointer wrapped to 0 so req1 beats req2
        set_req(1, 1'b0, 32'h600, 32'h0);
        set_req(2, 1'b0, 32'h700, 32'h0);
        req_sel = 4'b0110;
        wait_grant(1, 32'h600, 1'b0, 32'h0);
        complete(1, 32'h6666, 1'b0, 0, 3);
        check("rdata_held", req_rdata, 32'h6666);
        @(negedge clk);
        check("regrant_sel", 32'(mst_if.mst_sel_out), 32'd1);
        wait_grant(2, 32'h700, 1'b0, 32'h0);
        req_sel = '0;
        complete(2, 32'h7777, 1'b0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end
endmodule : tb_apb_master_arbiter
